// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises the raw key and a divided sample clock, then accepts a
// level change after STABLE_SAMPLES matching strobes. Define BUTTON_DEBOUNCER_RELEASE_PULSE_EN
// to add a release_pulse output.
module button_debouncer #(
  parameter int unsigned STABLE_SAMPLES    = 8,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_clk,
  input  logic button_in,
  output logic button_level,
  output logic button_pulse
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  ,
  output logic release_pulse
`endif
);

  localparam int unsigned     CntW    = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_SAMPLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 255) begin : g_bad_param
    $error("button_debouncer: STABLE_SAMPLES must be in 2..255");
  end

  typedef enum logic [1:0] {StReleased, StPressWait, StPressed, StReleaseWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      btn_sync_q;
  logic [1:0]      smp_sync_q;
  logic            smp_hist_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic            strobe;
  logic            pressed;
  logic            accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync_q <= '0;
      smp_sync_q <= '0;
      smp_hist_q <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], button_in};
      smp_sync_q <= {smp_sync_q[0], sample_clk};
      smp_hist_q <= smp_sync_q[1];
    end
  end

  assign pressed = btn_sync_q[1] ^ BUTTON_ACTIVE_LOW;
  assign strobe  = smp_sync_q[1] & ~smp_hist_q;
  assign accept  = strobe && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReleased;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // State and counter only move on a strobe; otherwise they hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (strobe) begin
      unique case (state_q)
        StReleased: begin
          if (pressed) begin
            state_d = StPressWait;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        StPressWait: begin
          if (!pressed) begin
            state_d = StReleased;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!pressed) begin
            state_d = StReleaseWait;
            cnt_d   = CntOne;
          end
        end
        StReleaseWait: begin
          if (pressed) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StReleased;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    if (accept && state_q == StPressWait && pressed) begin
      level_d = 1'b1;
      pulse_d = 1'b1;
    end
    if (accept && state_q == StReleaseWait && !pressed) begin
      level_d = 1'b0;
    end
  end

  assign button_level = level_q;
  assign button_pulse = pulse_q;

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  logic rel_pulse_q, rel_pulse_d;

  assign rel_pulse_d = accept && state_q == StReleaseWait && !pressed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_pulse_q <= 1'b0;
    end else begin
      rel_pulse_q <= rel_pulse_d;
    end
  end

  assign release_pulse = rel_pulse_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table with a scoreboard queue plus
// hand-written sequences for timing, reset, bounce and frozen-sample-clock corners.
module tb_button_debouncer;

  localparam int unsigned StableSamples = 4;

  logic clk = 1'b0;
  logic reset;
  logic sample_clk;
  logic button_in;
  logic button_level;
  logic button_pulse;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  logic release_pulse;
`endif

  button_debouncer #(
    .STABLE_SAMPLES   (StableSamples),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_clk   (sample_clk),
    .button_in    (button_in),
    .button_level (button_level),
    .button_pulse (button_pulse)
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int pulse_total = 0;
  int rel_total = 0;
  int run_len = 0;
  int max_run = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (button_pulse) pulse_total <= pulse_total + 1;
    run_len <= button_pulse ? run_len + 1 : 0;
    if (button_pulse && run_len + 1 > max_run) max_run <= run_len + 1;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    if (release_pulse) rel_total <= rel_total + 1;
    if (release_pulse && button_pulse) overlap <= overlap + 1;
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Key given as logical "pressed"; active-low pin.
  task automatic set_pressed(input bit p);
    button_in = ~p;
  endtask

  task automatic do_strobe();
    @(negedge clk) sample_clk = 1'b1;
    repeat (20) @(negedge clk);
    sample_clk = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) do_strobe();
  endtask

  typedef struct {
    bit pressed;
    int n_strobes;
    bit exp_level;
    int exp_pulses;
    int exp_rel;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  initial begin
    int p0, r0;
    int pat[5];
    vec_t exp;

    vecs[0]  = '{0, 2, 0, 0, 0};   // idle
    vecs[1]  = '{1, 3, 0, 0, 0};   // press, not yet qualified
    vecs[2]  = '{1, 1, 1, 1, 0};   // 4th strobe accepts
    vecs[3]  = '{1, 20, 1, 0, 0};  // held: no repeat
    vecs[4]  = '{0, 2, 1, 0, 0};   // release wait
    vecs[5]  = '{1, 1, 1, 0, 0};   // glitch back to pressed
    vecs[6]  = '{0, 3, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 1};   // 4th high sample accepts release
    vecs[8]  = '{1, 2, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0};
    vecs[10] = '{1, 3, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0};
    vecs[12] = '{1, 4, 1, 1, 0};

    reset = 1'b0;
    sample_clk = 1'b0;
    set_pressed(1'b0);
    repeat (3) @(negedge clk);
    check("reset_level", int'(button_level), 0);
    check("reset_pulse", int'(button_pulse), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      p0 = pulse_total;
      r0 = rel_total;
      set_pressed(vecs[i].pressed);
      sb.push_back(vecs[i]);
      strobes(vecs[i].n_strobes);
      exp = sb.pop_front();
      check($sformatf("vec%0d_level", i), int'(button_level), int'(exp.exp_level));
      check($sformatf("vec%0d_pulses", i), pulse_total - p0, exp.exp_pulses);
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
      check($sformatf("vec%0d_rel", i), rel_total - r0, exp.exp_rel);
`endif
    end

    // Exact acceptance edge: pulse on the 3rd clk edge after the 4th sample_clk rise.
    set_pressed(1'b0);
    strobes(4);
    check("released_again", int'(button_level), 0);
    set_pressed(1'b1);
    strobes(3);
    @(negedge clk) sample_clk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[k] = int'(button_pulse);
    end
    check("edge_k1", pat[0], 0);
    check("edge_k2", pat[1], 0);
    check("edge_k3", pat[2], 1);
    check("edge_k4", pat[3], 0);
    check("edge_k5", pat[4], 0);
    repeat (15) @(negedge clk);
    sample_clk = 1'b0;
    repeat (20) @(negedge clk);
    check("timed_level", int'(button_level), 1);

    // Asynchronous reset while pressed, then again mid-qualification.
    p0 = pulse_total;
    #2 reset = 1'b0;
    #1 check("rst_pressed_level", int'(button_level), 0);
    @(negedge clk) reset = 1'b1;
    strobes(3);
    check("requal_level", int'(button_level), 0);
    #2 reset = 1'b0;
    #1 check("rst_wait_level", int'(button_level), 0);
    check("rst_wait_pulse", int'(button_pulse), 0);
    @(negedge clk) reset = 1'b1;
    strobes(3);
    check("after_rst_3", int'(button_level), 0);
    strobes(1);
    check("after_rst_4", int'(button_level), 1);
    check("after_rst_pulses", pulse_total - p0, 1);

    // Bounce: key toggles every 50 clk while sampling every 40 clk.
    set_pressed(1'b0);
    strobes(4);
    check("pre_bounce_level", int'(button_level), 0);
    p0 = pulse_total;
    fork
      strobes(10);
      for (int t = 0; t < 8; t++) begin
        set_pressed(t % 2 == 0);
        repeat (50) @(negedge clk);
      end
    join
    set_pressed(1'b0);
    strobes(4);
    check("bounce_level", int'(button_level), 0);
    check("bounce_pulses", pulse_total - p0, 0);

    // Frozen sample clock: third press strobe, hold high 1000 clk with key toggling.
    set_pressed(1'b1);
    strobes(2);
    p0 = pulse_total;
    @(negedge clk) sample_clk = 1'b1;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (t % 37 == 0) button_in = ~button_in;
    end
    check("frozen_level", int'(button_level), 0);
    check("frozen_pulses", pulse_total - p0, 0);
    set_pressed(1'b1);
    repeat (5) @(negedge clk);
    sample_clk = 1'b0;
    repeat (20) @(negedge clk);
    check("frozen_level2", int'(button_level), 0);
    strobes(1);
    check("resume_level", int'(button_level), 1);
    check("resume_pulses", pulse_total - p0, 1);

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    r0 = rel_total;
    set_pressed(1'b0);
    strobes(4);
    check("rel_pulse_count", rel_total - r0, 1);
`endif
    check("pulse_width_max", max_run, 1);
    check("pulse_rel_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Consumes the slow square wave from the clock divider stage and uses each of its rising edges as a sample strobe.
- Cleans a raw, asynchronous push-button input before it reaches the multiplier/divider/square-root control FSM.
- Produces a debounced level and a single-clk-cycle press pulse, both synchronous to clk.
- Sits between the board key pins and the operation-start logic.

Parameters:
- STABLE_SAMPLES, 8: consecutive identical samples required to accept a level change. Legal range 2..255.
- BUTTON_ACTIVE_LOW, 1: 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.

Ports:
- clk  input  1  system clock, 50 MHz reference.
- reset  input  1  asynchronous, active-low reset.
- sample_clk  input  1  divided square wave from the clock divider stage, e.g. 1 kHz; asynchronous to this block's logic.
- button_in  input  1  raw key pin, bouncing, asynchronous.
- button_level  output  1  debounced level; 1 = pressed.
- button_pulse  output  1  one clk-cycle pulse on each accepted press.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low. reset = 0 immediately clears all flops; release is sampled on posedge clk.
- Reset values:
  - button_level = 0, button_pulse = 0.
  - All synchronizer flops = 0.
  - Sample counter = 0; state = RELEASED.
- Synchronization:
  - button_in passes through 2 flops.
  - Normalized: pressed = sync ^ BUTTON_ACTIVE_LOW.
  - sample_clk passes through 2 flops plus 1 history flop.
  - strobe = sync & ~history, high for exactly one clk per sample_clk rising edge.
  - strobe asserts 3 clk edges after a sample_clk rise.
- Counter: width $clog2(STABLE_SAMPLES+1). It never exceeds STABLE_SAMPLES-1 and never wraps.
- FSM states and transitions (all evaluated only on clk edges where strobe=1; otherwise state and counter hold):
  - RELEASED:
    - pressed=1 -> PRESS_WAIT, cnt=1.
    - else stay, cnt=0.
  - PRESS_WAIT:
    - pressed=0 -> RELEASED, cnt=0 (bounce rejected).
    - pressed=1 and cnt+1==STABLE_SAMPLES -> PRESSED, cnt=0, button_level<=1, button_pulse<=1.
    - pressed=1 otherwise -> cnt<=cnt+1.
  - PRESSED:
    - pressed=0 -> RELEASE_WAIT, cnt=1.
    - else stay.
  - RELEASE_WAIT:
    - pressed=1 -> PRESSED, cnt=0.
    - pressed=0 and cnt+1==STABLE_SAMPLES -> RELEASED, cnt=0, button_level<=0.
    - pressed=0 otherwise -> cnt<=cnt+1.
- Acceptance rule: a change is accepted on the STABLE_SAMPLES-th consecutive strobe that sees the new value.
- Register timing:
  - button_level and button_pulse are registered.
  - Both change on the same clk edge as the accepting transition.
  - button_pulse deasserts on the next clk edge unconditionally.
- Held key: exactly one pulse per accepted press, no repeat.
- Stopped sample_clk (held constant): no strobes, so all state freezes; outputs keep their values, pulse stays 0.
- Reset asserted mid-wait or while PRESSED: immediate return to reset values, no pulse emitted. After release, a key still held must be re-qualified from RELEASED.
- Illegal STABLE_SAMPLES (<2 or >255): elaboration-time $error.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_RELEASE_PULSE_EN.
- When defined:
  - Adds output port release_pulse (output, 1 bit, reset value 0).
  - release_pulse is high for one clk on the edge where RELEASE_WAIT -> RELEASED is accepted.
  - It is never high in the same cycle as button_pulse.
- When undefined:
  - The port does not exist.
  - No extra flops are synthesized.
  - All other behaviour is identical.

Test Plan:
- Clean press: STABLE_SAMPLES=4, ACTIVE_LOW=1, sample_clk period 40 clk; drive button_in 1->0 and hold -> button_level=1 and button_pulse=1 for exactly 1 clk, on the clk edge that the 4th strobe after the first low sample is evaluated; no further pulses over 20 strobes.
- Bounce rejection: toggle button_in low/high every 50 clk for 400 clk (never 4 consecutive low samples), then hold high -> button_level stays 0, button_pulse never asserts, FSM returns to RELEASED.
- Release with glitch: from PRESSED, release for 2 strobes, re-press for 1 strobe, then release steadily -> level stays 1 through the glitch; falls to 0 only after 4 consecutive high samples; no button_pulse during release.
- Reset mid-operation: assert reset during PRESS_WAIT with cnt=3 -> outputs 0 immediately (asynchronous); after release with key held, a new pulse appears only after 4 fresh strobes.
- Frozen sample clock: hold sample_clk=1 for 1000 clk while toggling button_in -> no state or output change; resuming sample_clk resumes qualification from the held state.
- With BUTTON_DEBOUNCER_RELEASE_PULSE_EN defined: run a full press/release -> one button_pulse on press acceptance, one release_pulse on release acceptance, never overlapping; with the macro undefined, the same stimulus passes the first five scenarios unchanged.
